serial_word_feeder: RTL

// - Upstream feeder for sequence_detector_shift_regs: accepts parallel words over valid/ready and serialises them

---
 rtl/serial_word_feeder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_word_feeder.sv
// serial_word_feeder
// Takes parallel words over a valid/ready handshake and serialises them onto a
// one-bit stream, one bit per clk. A one-entry holding buffer feeds the shifter,
// so back-to-back words leave no gap in the stream; idle cycles carry IDLE_BIT.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   word_in     parallel word, taken when word_valid & word_ready
//   word_valid  word_in holds a word to send
//   word_ready  feeder can accept word_in this cycle
//   serial_out  serial bit stream
//   bit_valid   serial_out carries a word bit (0 = idle filler)
//   last_bit    serial_out carries the final bit of a word
//   busy        holding buffer or shifter occupied
//   words_sent  words fully shifted out, wraps modulo 2^CNT_W
//
// state   | meaning
// S_IDLE  | shifter empty, serial_out = IDLE_BIT
// S_SHIFT | shifter active, serial_out carries a word bit

module serial_word_feeder #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   parameter bit IDLE_BIT  = 1'b0,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] word_in,
   input  logic             word_valid,
   output logic             word_ready,
   output logic             serial_out,
   output logic             bit_valid,
   output logic             last_bit,
   output logic             busy,
   output logic [CNT_W-1:0] words_sent
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] buf_q;
   logic             buf_full_q;
   logic [WIDTH-1:0] sh_q;
   logic [CW-1:0]    cnt_q;
   logic             serial_q;
   logic             bit_valid_q;
   logic             last_q;
   logic [CNT_W-1:0] words_q;

   logic             sh_last;
   logic             load_now;
   logic             accept;
   logic             first_bit;
   logic [WIDTH-1:0] first_rest;
   logic             next_bit;
   logic [WIDTH-1:0] next_rest;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (buf_full_q) state_d = S_SHIFT;
         S_SHIFT: if (sh_last && !buf_full_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // cnt_q is a down-counter of bits still to emit after the one on serial_out;
   // terminal count 0 means the current bit is the last of the word.
   always_comb begin
      sh_last    = (state_q == S_SHIFT) && (cnt_q == '0);
      // load_now looks only at registered state, so word_ready never depends
      // combinationally on word_valid.
      load_now   = buf_full_q && ((state_q == S_IDLE) || sh_last);
      word_ready = !reset && (!buf_full_q || load_now);
      accept     = word_valid && word_ready;
      if (MSB_FIRST != 0) begin
         first_bit  = buf_q[WIDTH-1];
         first_rest = buf_q << 1;
         next_bit   = sh_q[WIDTH-1];
         next_rest  = sh_q << 1;
      end else begin
         first_bit  = buf_q[0];
         first_rest = buf_q >> 1;
         next_bit   = sh_q[0];
         next_rest  = sh_q >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         sh_q        <= '0;
         cnt_q       <= '0;
         serial_q    <= IDLE_BIT;
         bit_valid_q <= 1'b0;
         last_q      <= 1'b0;
         words_q     <= '0;
      end else begin
         // accept wins over load so the buffer can refill on the load edge
         if (accept) begin
            buf_q      <= word_in;
            buf_full_q <= 1'b1;
         end else if (load_now) begin
            buf_full_q <= 1'b0;
         end

         if (sh_last) words_q <= words_q + CNT_W'(1);

         if (load_now) begin
            serial_q    <= first_bit;
            sh_q        <= first_rest;
            cnt_q       <= CW'(WIDTH - 1);
            bit_valid_q <= 1'b1;
            last_q      <= 1'b0;
         end else if (state_q == S_SHIFT && cnt_q != '0) begin
            serial_q <= next_bit;
            sh_q     <= next_rest;
            cnt_q    <= cnt_q - CW'(1);
            last_q   <= (cnt_q == CW'(1));
         end else if (sh_last) begin
            serial_q    <= IDLE_BIT;
            bit_valid_q <= 1'b0;
            last_q      <= 1'b0;
         end
      end
   end

   assign serial_out = serial_q;
   assign bit_valid  = bit_valid_q;
   assign last_bit   = last_q;
   assign words_sent = words_q;
   assign busy       = buf_full_q || (state_q == S_SHIFT);

endmodule
